core_s3_lsu: RTL and testbench

Stage-3 load/store unit of the LETC core. It consumes the stage-2 ALU result as an effective address or pass-through value, together with the store data and memory opcode. It runs the data-cache request/response handshake through a small FSM, then aligns, extends and registers the writeback value for stage 4. Non-memory instructions pass through in one cycle.

---
 rtl/core_pkg.sv | 48 ++++
 rtl/core_s3_lsu_align.sv | 64 ++++++
 rtl/core_s3_lsu.sv | 176 +++++++++++++++++
 tb/tb_core_s3_lsu.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types for the LETC core stage-3 load/store unit.
package core_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_IDX = 5;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [3:0] {
        MEM_NONE,
        MEM_LB,
        MEM_LH,
        MEM_LW,
        MEM_LBU,
        MEM_LHU,
        MEM_SB,
        MEM_SH,
        MEM_SW
    } memop_e;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT_RSP,
        LSU_DRAIN
    } lsu_state_e;

    typedef struct packed {
        word_t              rd_wdata;
        logic [REG_IDX-1:0] rd_idx;
        logic               rd_we;
        logic               misaligned;
    } s3_to_s4_s;

    function automatic logic is_store(memop_e op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    // Halfword ops need addr[0]=0, word ops need addr[1:0]=0.
    function automatic logic is_misaligned(memop_e op, logic [1:0] off);
        logic half_op;
        logic word_op;
        half_op = (op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH);
        word_op = (op == MEM_LW) || (op == MEM_SW);
        return (half_op && off[0]) || (word_op && (off != 2'b00));
    endfunction

endpackage

// File: rtl/core_s3_lsu_align.sv
// Combinational load lane extraction/extension and store lane replication/strobes.
module core_s3_lsu_align
    import core_pkg::*;
(
    input  memop_e     i_ld_memop,
    input  logic [1:0] i_ld_off,
    input  word_t      i_ld_rdata,
    output word_t      o_ld_data,
    input  memop_e     i_st_memop,
    input  logic [1:0] i_st_off,
    input  word_t      i_st_data,
    output word_t      o_st_wdata,
    output logic [3:0] o_st_wstrb
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_ld_rdata[7:0];
        case (i_ld_off)
            2'd0:    w_byte = i_ld_rdata[7:0];
            2'd1:    w_byte = i_ld_rdata[15:8];
            2'd2:    w_byte = i_ld_rdata[23:16];
            default: w_byte = i_ld_rdata[31:24];
        endcase
        w_half = i_ld_off[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];

        o_ld_data = '0;
        case (i_ld_memop)
            MEM_LB:  o_ld_data = {{24{w_byte[7]}}, w_byte};
            MEM_LBU: o_ld_data = {24'd0, w_byte};
            MEM_LH:  o_ld_data = {{16{w_half[15]}}, w_half};
            MEM_LHU: o_ld_data = {16'd0, w_half};
            MEM_LW:  o_ld_data = i_ld_rdata;
            default: o_ld_data = '0;
        endcase
    end

    // Low address bits below the access size are ignored here.
    always_comb begin
        o_st_wdata = '0;
        o_st_wstrb = 4'b0000;
        case (i_st_memop)
            MEM_SB: begin
                o_st_wdata = {4{i_st_data[7:0]}};
                o_st_wstrb = 4'b0001 << i_st_off;
            end
            MEM_SH: begin
                o_st_wdata = {2{i_st_data[15:0]}};
                o_st_wstrb = 4'b0011 << {i_st_off[1], 1'b0};
            end
            MEM_SW: begin
                o_st_wdata = i_st_data;
                o_st_wstrb = 4'b1111;
            end
            default: begin
                o_st_wdata = '0;
                o_st_wstrb = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/core_s3_lsu.sv
// LETC stage-3 load/store unit: data-cache handshake FSM and stage-4 output register.
// Optional misaligned-access trapping is enabled by LETC_CORE_S3_MISALIGN_CHECK_EN.
module core_s3_lsu
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s2_valid,
    output logic        s3_ready,
    input  logic [31:0] s2_alu_result,
    input  logic [31:0] s2_rs2_rdata,
    input  memop_e      s2_memop,
    input  logic [4:0]  s2_rd_idx,
    input  logic        s2_rd_we,
    input  logic        flush,
    output logic        dcache_req_valid,
    input  logic        dcache_req_ready,
    output logic [31:0] dcache_req_addr,
    output logic        dcache_req_we,
    output logic [31:0] dcache_req_wdata,
    output logic [3:0]  dcache_req_wstrb,
    input  logic        dcache_rsp_valid,
    input  logic [31:0] dcache_rsp_rdata,
    output logic        s3_valid,
    input  logic        s4_ready,
    output logic [31:0] s3_rd_wdata,
    output logic [4:0]  s3_rd_idx,
    output logic        s3_rd_we,
    output logic        s3_misaligned
);

    lsu_state_e  r_state;
    memop_e      r_memop;
    logic [1:0]  r_off;
    logic [4:0]  r_rd_idx;
    logic        r_rd_we;
    logic        r_req_valid;
    word_t       r_req_addr;
    logic        r_req_we;
    word_t       r_req_wdata;
    logic [3:0]  r_req_wstrb;
    logic        r_s3_valid;
    s3_to_s4_s   r_out;

    logic        w_accept;
    logic        w_misaligned;
    logic        w_req_hs;
    word_t       w_ld_data;
    word_t       w_st_wdata;
    logic [3:0]  w_st_wstrb;

`ifdef LETC_CORE_S3_MISALIGN_CHECK_EN
    assign w_misaligned = is_misaligned(s2_memop, s2_alu_result[1:0]);
`else
    assign w_misaligned = 1'b0;
`endif

    assign s3_ready = (r_state == LSU_IDLE) && (!r_s3_valid || s4_ready);
    assign w_accept = s2_valid && s3_ready && !flush;
    assign w_req_hs = r_req_valid && dcache_req_ready;

    core_s3_lsu_align u_align (
        .i_ld_memop (r_memop),
        .i_ld_off   (r_off),
        .i_ld_rdata (dcache_rsp_rdata),
        .o_ld_data  (w_ld_data),
        .i_st_memop (s2_memop),
        .i_st_off   (s2_alu_result[1:0]),
        .i_st_data  (s2_rs2_rdata),
        .o_st_wdata (w_st_wdata),
        .o_st_wstrb (w_st_wstrb)
    );

    // FSM, request registers and output register; flush beats any output load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= LSU_IDLE;
            r_memop     <= MEM_NONE;
            r_off       <= 2'b00;
            r_rd_idx    <= '0;
            r_rd_we     <= 1'b0;
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_req_we    <= 1'b0;
            r_req_wdata <= '0;
            r_req_wstrb <= 4'b0000;
            r_s3_valid  <= 1'b0;
            r_out       <= '0;
        end else begin
            if (r_s3_valid && s4_ready) begin
                r_s3_valid <= 1'b0;
            end
            if (flush) begin
                r_s3_valid <= 1'b0;
            end

            case (r_state)
                LSU_IDLE: begin
                    if (w_accept) begin
                        if ((s2_memop == MEM_NONE) || w_misaligned) begin
                            r_s3_valid       <= 1'b1;
                            r_out.rd_wdata   <= s2_alu_result;
                            r_out.rd_idx     <= s2_rd_idx;
                            r_out.rd_we      <= s2_rd_we && !w_misaligned;
                            r_out.misaligned <= w_misaligned;
                        end else begin
                            r_memop     <= s2_memop;
                            r_off       <= s2_alu_result[1:0];
                            r_rd_idx    <= s2_rd_idx;
                            r_rd_we     <= s2_rd_we;
                            r_req_valid <= 1'b1;
                            r_req_addr  <= {s2_alu_result[31:2], 2'b00};
                            r_req_we    <= is_store(s2_memop);
                            r_req_wdata <= w_st_wdata;
                            r_req_wstrb <= w_st_wstrb;
                            r_state     <= LSU_REQ;
                        end
                    end
                end
                LSU_REQ: begin
                    if (w_req_hs) begin
                        r_req_valid <= 1'b0;
                        if (r_req_we) begin
                            r_state <= LSU_IDLE;
                            if (!flush) begin
                                r_s3_valid       <= 1'b1;
                                r_out.rd_wdata   <= '0;
                                r_out.rd_idx     <= r_rd_idx;
                                r_out.rd_we      <= 1'b0;
                                r_out.misaligned <= 1'b0;
                            end
                        end else begin
                            // A load the cache took while being flushed still owes a response.
                            r_state <= flush ? LSU_DRAIN : LSU_WAIT_RSP;
                        end
                    end else if (flush) begin
                        r_req_valid <= 1'b0;
                        r_state     <= LSU_IDLE;
                    end
                end
                LSU_WAIT_RSP: begin
                    if (dcache_rsp_valid) begin
                        r_state <= LSU_IDLE;
                        if (!flush) begin
                            r_s3_valid       <= 1'b1;
                            r_out.rd_wdata   <= w_ld_data;
                            r_out.rd_idx     <= r_rd_idx;
                            r_out.rd_we      <= r_rd_we;
                            r_out.misaligned <= 1'b0;
                        end
                    end else if (flush) begin
                        r_state <= LSU_DRAIN;
                    end
                end
                LSU_DRAIN: begin
                    if (dcache_rsp_valid) begin
                        r_state <= LSU_IDLE;
                    end
                end
                default: r_state <= LSU_IDLE;
            endcase
        end
    end

    assign dcache_req_valid = r_req_valid;
    assign dcache_req_addr  = r_req_addr;
    assign dcache_req_we    = r_req_we;
    assign dcache_req_wdata = r_req_wdata;
    assign dcache_req_wstrb = r_req_wstrb;
    assign s3_valid         = r_s3_valid;
    assign s3_rd_wdata      = r_out.rd_wdata;
    assign s3_rd_idx        = r_out.rd_idx;
    assign s3_rd_we         = r_out.rd_we;
    assign s3_misaligned    = r_out.misaligned;

endmodule

// File: tb/tb_core_s3_lsu.sv
// Self-checking bench for core_s3_lsu: directed plan cases plus randomized traffic against a behavioural model.
module tb_core_s3_lsu;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s2_valid;
    logic        s3_ready;
    logic [31:0] s2_alu_result;
    logic [31:0] s2_rs2_rdata;
    memop_e      s2_memop;
    logic [4:0]  s2_rd_idx;
    logic        s2_rd_we;
    logic        flush;
    logic        dcache_req_valid;
    logic        dcache_req_ready;
    logic [31:0] dcache_req_addr;
    logic        dcache_req_we;
    logic [31:0] dcache_req_wdata;
    logic [3:0]  dcache_req_wstrb;
    logic        dcache_rsp_valid;
    logic [31:0] dcache_rsp_rdata;
    logic        s3_valid;
    logic        s4_ready;
    logic [31:0] s3_rd_wdata;
    logic [4:0]  s3_rd_idx;
    logic        s3_rd_we;
    logic        s3_misaligned;

    core_s3_lsu dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s2_valid         (s2_valid),
        .s3_ready         (s3_ready),
        .s2_alu_result    (s2_alu_result),
        .s2_rs2_rdata     (s2_rs2_rdata),
        .s2_memop         (s2_memop),
        .s2_rd_idx        (s2_rd_idx),
        .s2_rd_we         (s2_rd_we),
        .flush            (flush),
        .dcache_req_valid (dcache_req_valid),
        .dcache_req_ready (dcache_req_ready),
        .dcache_req_addr  (dcache_req_addr),
        .dcache_req_we    (dcache_req_we),
        .dcache_req_wdata (dcache_req_wdata),
        .dcache_req_wstrb (dcache_req_wstrb),
        .dcache_rsp_valid (dcache_rsp_valid),
        .dcache_rsp_rdata (dcache_rsp_rdata),
        .s3_valid         (s3_valid),
        .s4_ready         (s4_ready),
        .s3_rd_wdata      (s3_rd_wdata),
        .s3_rd_idx        (s3_rd_idx),
        .s3_rd_we         (s3_rd_we),
        .s3_misaligned    (s3_misaligned)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model: phase of the in-flight memory op (0 none, 1 awaiting request, 2 awaiting response, 3 discarding response).
    int          m_phase;
    memop_e      m_op;
    logic [31:0] m_addr;
    logic [31:0] m_rs2;
    logic [4:0]  m_rd;
    logic        m_rdwe;
    logic        m_v;
    logic [31:0] m_wd;
    logic [4:0]  m_idx;
    logic        m_we;
    logic        m_mis;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int op_size(memop_e op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 1;
            MEM_LH, MEM_LHU, MEM_SH: return 2;
            MEM_LW, MEM_SW:          return 4;
            default:                 return 0;
        endcase
    endfunction

    function automatic bit op_is_store(memop_e op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic bit op_signed(memop_e op);
        return (op == MEM_LB) || (op == MEM_LH);
    endfunction

    function automatic logic [1:0] lane_off(memop_e op, logic [31:0] a);
        int sz = op_size(op);
        int o  = int'(a[1:0]);
        if (sz > 0) o = o - (o % sz);
        return 2'(o);
    endfunction

    function automatic logic [31:0] model_load(memop_e op, logic [31:0] a, logic [31:0] rdata);
        int sz = op_size(op);
        logic [31:0] v;
        logic [31:0] msk;
        v = rdata >> (8 * int'(lane_off(op, a)));
        if (sz < 4) begin
            msk = (32'h1 << (8 * sz)) - 32'h1;
            v   = v & msk;
            if (op_signed(op) && v[8*sz-1]) v = v | ~msk;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_wdata(memop_e op, logic [31:0] rs2);
        int sz = op_size(op);
        logic [31:0] w = '0;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = rs2[8*(b % sz) +: 8];
        return w;
    endfunction

    function automatic logic [3:0] model_wstrb(memop_e op, logic [31:0] a);
        int sz = op_size(op);
        return 4'(((1 << sz) - 1) << int'(lane_off(op, a)));
    endfunction

    function automatic bit model_mis(memop_e op, logic [31:0] a);
`ifdef LETC_CORE_S3_MISALIGN_CHECK_EN
        int sz = op_size(op);
        return (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
`else
        return (op == MEM_NONE) && (a === 32'hx);
`endif
    endfunction

    function automatic bit exp_ready();
        return (m_phase == 0) && (!m_v || s4_ready);
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_op    = MEM_NONE;
        m_addr  = '0;
        m_rs2   = '0;
        m_rd    = '0;
        m_rdwe  = 1'b0;
        m_v     = 1'b0;
        m_wd    = '0;
        m_idx   = '0;
        m_we    = 1'b0;
        m_mis   = 1'b0;
    endtask

    task automatic load_out(input logic [31:0] wd, input logic [4:0] idx, input logic we, input logic mis);
        m_v   = 1'b1;
        m_wd  = wd;
        m_idx = idx;
        m_we  = we;
        m_mis = mis;
    endtask

    // Advance the model by one clock edge using the inputs the bench is driving.
    task automatic model_step();
        bit acc;
        bit mis;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc = s2_valid && exp_ready() && !flush;
        if (m_v && s4_ready) m_v = 1'b0;
        if (flush) m_v = 1'b0;
        case (m_phase)
            0: if (acc) begin
                mis = model_mis(s2_memop, s2_alu_result);
                if (s2_memop == MEM_NONE || mis) begin
                    load_out(s2_alu_result, s2_rd_idx, s2_rd_we && !mis, mis);
                end else begin
                    m_op    = s2_memop;
                    m_addr  = s2_alu_result;
                    m_rs2   = s2_rs2_rdata;
                    m_rd    = s2_rd_idx;
                    m_rdwe  = s2_rd_we;
                    m_phase = 1;
                end
            end
            1: if (dcache_req_ready) begin
                if (op_is_store(m_op)) begin
                    m_phase = 0;
                    if (!flush) load_out(32'h0, m_rd, 1'b0, 1'b0);
                end else begin
                    m_phase = flush ? 3 : 2;
                end
            end else if (flush) begin
                m_phase = 0;
            end
            2: if (dcache_rsp_valid) begin
                m_phase = 0;
                if (!flush) load_out(model_load(m_op, m_addr, dcache_rsp_rdata), m_rd, m_rdwe, 1'b0);
            end else if (flush) begin
                m_phase = 3;
            end
            default: if (dcache_rsp_valid) m_phase = 0;
        endcase
    endtask

    task automatic check_regs();
        chk("s3_valid", 32'(s3_valid), 32'(m_v));
        if (m_v) begin
            chk("s3_rd_we", 32'(s3_rd_we), 32'(m_we));
            chk("s3_misaligned", 32'(s3_misaligned), 32'(m_mis));
            if (m_we || m_mis) begin
                chk("s3_rd_wdata", s3_rd_wdata, m_wd);
                chk("s3_rd_idx", 32'(s3_rd_idx), 32'(m_idx));
            end
        end
        chk("req_valid", 32'(dcache_req_valid), 32'(m_phase == 1));
        if (m_phase == 1) begin
            chk("req_addr", dcache_req_addr, {m_addr[31:2], 2'b00});
            chk("req_we", 32'(dcache_req_we), 32'(op_is_store(m_op)));
            if (op_is_store(m_op)) begin
                chk("req_wdata", dcache_req_wdata, model_wdata(m_op, m_rs2));
                chk("req_wstrb", 32'(dcache_req_wstrb), 32'(model_wstrb(m_op, m_addr)));
            end
        end
    endtask

    // One cycle: check the combinational ready, clock, update model, check registered outputs.
    task automatic step();
        #1;
        chk("s3_ready", 32'(s3_ready), 32'(exp_ready()));
        assert (!dcache_rsp_valid || m_phase == 2 || m_phase == 3)
            else $error("bench drove a response with no load outstanding");
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_regs();
    endtask

    task automatic idle_in();
        s2_valid         = 1'b0;
        s2_memop         = MEM_NONE;
        s2_alu_result    = '0;
        s2_rs2_rdata     = '0;
        s2_rd_idx        = '0;
        s2_rd_we         = 1'b0;
        flush            = 1'b0;
        dcache_req_ready = 1'b0;
        dcache_rsp_valid = 1'b0;
        dcache_rsp_rdata = '0;
        s4_ready         = 1'b1;
    endtask

    task automatic send(input memop_e op, input logic [31:0] alu, input logic [31:0] rs2,
                        input logic [4:0] rd, input logic we);
        s2_valid      = 1'b1;
        s2_memop      = op;
        s2_alu_result = alu;
        s2_rs2_rdata  = rs2;
        s2_rd_idx     = rd;
        s2_rd_we      = we;
        step();
        s2_valid      = 1'b0;
        s2_memop      = MEM_NONE;
    endtask

    task automatic handshake();
        dcache_req_ready = 1'b1;
        step();
        dcache_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rdata);
        dcache_rsp_valid = 1'b1;
        dcache_rsp_rdata = rdata;
        step();
        dcache_rsp_valid = 1'b0;
    endtask

    initial begin
        idle_in();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_s3_valid", 32'(s3_valid), 32'h0);
        chk("rst_req_valid", 32'(dcache_req_valid), 32'h0);
        chk("rst_req_addr", dcache_req_addr, 32'h0);
        chk("rst_req_wdata", dcache_req_wdata, 32'h0);
        chk("rst_req_wstrb", 32'(dcache_req_wstrb), 32'h0);
        chk("rst_req_we", 32'(dcache_req_we), 32'h0);
        chk("rst_rd_wdata", s3_rd_wdata, 32'h0);
        chk("rst_rd_idx", 32'(s3_rd_idx), 32'h0);
        chk("rst_rd_we", 32'(s3_rd_we), 32'h0);
        chk("rst_misaligned", 32'(s3_misaligned), 32'h0);
        chk("rst_s3_ready", 32'(s3_ready), 32'h1);

        // NONE pass-through
        send(MEM_NONE, 32'h1234_5678, 32'h0, 5'd5, 1'b1);
        chk("none_valid", 32'(s3_valid), 32'h1);
        chk("none_wdata", s3_rd_wdata, 32'h1234_5678);
        chk("none_idx", 32'(s3_rd_idx), 32'd5);
        chk("none_we", 32'(s3_rd_we), 32'h1);
        step();

        // LB / LBU from the top byte lane
        send(MEM_LB, 32'h0000_1003, 32'h0, 5'd7, 1'b1);
        chk("lb_req_valid", 32'(dcache_req_valid), 32'h1);
        chk("lb_req_addr", dcache_req_addr, 32'h0000_1000);
        chk("lb_req_we", 32'(dcache_req_we), 32'h0);
        handshake();
        respond(32'h80FF_FF7F);
        chk("lb_wdata", s3_rd_wdata, 32'hFFFF_FF80);
        step();
        send(MEM_LBU, 32'h0000_1003, 32'h0, 5'd8, 1'b1);
        handshake();
        respond(32'h80FF_FF7F);
        chk("lbu_wdata", s3_rd_wdata, 32'h0000_0080);
        step();

        // SH to the upper half
        send(MEM_SH, 32'h0000_2002, 32'hAAAA_BEEF, 5'd9, 1'b1);
        chk("sh_addr", dcache_req_addr, 32'h0000_2000);
        chk("sh_wdata", dcache_req_wdata, 32'hBEEF_BEEF);
        chk("sh_wstrb", 32'(dcache_req_wstrb), 32'hC);
        chk("sh_we", 32'(dcache_req_we), 32'h1);
        handshake();
        chk("sh_s3_valid", 32'(s3_valid), 32'h1);
        chk("sh_rd_we", 32'(s3_rd_we), 32'h0);
        step();

        // LW with a stalled cache, then a stalled stage 4
        send(MEM_LW, 32'h0000_4000, 32'h0, 5'd10, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("lw_stall_ready", 32'(s3_ready), 32'h0);
            chk("lw_stall_addr", dcache_req_addr, 32'h0000_4000);
        end
        handshake();
        s4_ready = 1'b0;
        respond(32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lw_hold_wdata", s3_rd_wdata, 32'hCAFE_F00D);
            chk("lw_hold_ready", 32'(s3_ready), 32'h0);
        end
        s4_ready = 1'b1;
        step();

        // Flush while waiting for the response
        send(MEM_LW, 32'h0000_5000, 32'h0, 5'd11, 1'b1);
        handshake();
        flush = 1'b1;
        step();
        flush = 1'b0;
        respond(32'hDEAD_BEEF);
        chk("flush_no_valid", 32'(s3_valid), 32'h0);
        send(MEM_NONE, 32'h0BAD_F00D, 32'h0, 5'd3, 1'b1);
        chk("flush_next_wdata", s3_rd_wdata, 32'h0BAD_F00D);
        step();

        // Misaligned word load
        send(MEM_LW, 32'h0000_3001, 32'h0, 5'd12, 1'b1);
`ifdef LETC_CORE_S3_MISALIGN_CHECK_EN
        chk("mis_req_valid", 32'(dcache_req_valid), 32'h0);
        chk("mis_flag", 32'(s3_misaligned), 32'h1);
        chk("mis_wdata", s3_rd_wdata, 32'h0000_3001);
        step();
`else
        chk("mis_req_valid", 32'(dcache_req_valid), 32'h1);
        chk("mis_req_addr", dcache_req_addr, 32'h0000_3000);
        handshake();
        respond(32'h1357_9BDF);
        chk("mis_off_wdata", s3_rd_wdata, 32'h1357_9BDF);
        step();
`endif

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            s2_valid         = ($urandom_range(0, 2) != 0);
            s2_memop         = memop_e'(4'($urandom_range(0, 8)));
            s2_alu_result    = $urandom;
            s2_rs2_rdata     = $urandom;
            s2_rd_idx        = 5'($urandom_range(0, 31));
            s2_rd_we         = 1'($urandom_range(0, 1));
            s4_ready         = ($urandom_range(0, 3) != 0);
            flush            = ($urandom_range(0, 15) == 0);
            dcache_req_ready = (m_phase == 1) && !flush && ($urandom_range(0, 1) == 1);
            dcache_rsp_valid = (m_phase == 2 || m_phase == 3) && !flush && ($urandom_range(0, 2) == 0);
            dcache_rsp_rdata = $urandom;
            step();
        end

        idle_in();
        for (int c = 0; c < 8; c++) begin
            if (m_phase == 1) dcache_req_ready = 1'b1;
            else if (m_phase == 2 || m_phase == 3) dcache_rsp_valid = 1'b1;
            step();
            dcache_req_ready = 1'b0;
            dcache_rsp_valid = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
